// File: rtl/doorlock_pkg.sv
// Shared definitions for the doorlock button protocol: FSM encoding,
// button indices and default timing used by doorlock, the code sender and benches.
package doorlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_PRESS,
    ST_GAP,
    ST_WAIT_RES,
    ST_DONE
  } state_e;

  localparam logic [1:0] BT_0    = 2'd0;
  localparam logic [1:0] BT_1    = 2'd1;
  localparam logic [1:0] BT_2    = 2'd2;
  localparam logic [1:0] BT_NONE = 2'd3;

  localparam int LEAD_CYC_DEF  = 1;
  localparam int PRESS_CYC_DEF = 1;
  localparam int GAP_CYC_DEF   = 4;
  localparam int WAIT_MAX_DEF  = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/doorlock_code_sender_if.sv
// Request/result and button/LED signals between the code sender and its user/doorlock.
interface doorlock_code_sender_if;
  logic       go;
  logic [1:0] code_0;
  logic [1:0] code_1;
  logic [1:0] code_2;
  logic       led_ok;
  logic       led_fail;
  logic       start;
  logic       bt_0;
  logic       bt_1;
  logic       bt_2;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;

  modport master (
    input  go, code_0, code_1, code_2, led_ok, led_fail,
    output start, bt_0, bt_1, bt_2, busy, done, pass, timeout
  );

  modport slave (
    output go, code_0, code_1, code_2, led_ok, led_fail,
    input  start, bt_0, bt_1, bt_2, busy, done, pass, timeout
  );
endinterface

// File: rtl/bt_onehot.sv
// Button index to one-hot press vector; index BT_NONE or enable low gives no press.
module bt_onehot
  import doorlock_pkg::*;
(
  input  logic [1:0] idx,
  input  logic       en,
  output logic [2:0] oh
);

  always_comb begin
    oh = 3'b000;
    if (en) begin
      case (idx)
        BT_0:    oh = 3'b001;
        BT_1:    oh = 3'b010;
        BT_2:    oh = 3'b100;
        default: oh = 3'b000;
      endcase
    end
  end

endmodule

// File: rtl/doorlock_code_sender.sv
// Drives a 3-digit code into doorlock as timed button presses, then
// waits for the LED verdict and reports pass / fail / timeout.
module doorlock_code_sender
  import doorlock_pkg::*;
#(
  parameter int LEAD_CYC  = LEAD_CYC_DEF,
  parameter int PRESS_CYC = PRESS_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF,
  parameter int WAIT_MAX  = WAIT_MAX_DEF
)(
  input  logic                   clk,
  input  logic                   n_rst,
  doorlock_code_sender_if.master bus
);

  localparam int CNT_MAX = max2(max2(LEAD_CYC, PRESS_CYC), max2(GAP_CYC, WAIT_MAX));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counters load N-1 on entry and the state exits on the edge that sees zero.
  localparam logic [CNT_W-1:0] LEAD_LD  = CNT_W'(LEAD_CYC - 1);
  localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_MAX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [2:0][1:0]  code_q, code_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       bt_q, bt_d;
  logic [1:0]       digit;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    code_d    = code_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          code_d    = {bus.code_2, bus.code_1, bus.code_0};
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          idx_d     = 2'd0;
          cnt_d     = LEAD_LD;
          state_d   = ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (cnt_zero) begin
          cnt_d   = PRESS_LD;
          state_d = ST_PRESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PRESS: begin
        if (cnt_zero) begin
          cnt_d   = GAP_LD;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q < 2'd2) begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = PRESS_LD;
          state_d = ST_PRESS;
        end else begin
          cnt_d   = WAIT_LD;
          state_d = ST_WAIT_RES;
        end
      end
      ST_WAIT_RES: begin
        // A fail indication wins when both LEDs are lit together.
        if (bus.led_fail) begin
          pass_d  = 1'b0;
          state_d = ST_DONE;
        end else if (bus.led_ok) begin
          pass_d  = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_zero) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    case (idx_d)
      2'd0:    digit = code_d[0];
      2'd1:    digit = code_d[1];
      2'd2:    digit = code_d[2];
      default: digit = BT_NONE;
    endcase
  end

  bt_onehot u_bt_onehot (
    .idx (digit),
    .en  (state_d == ST_PRESS),
    .oh  (bt_d)
  );

  always_comb begin
    start_d = state_d inside {ST_LEAD, ST_PRESS, ST_GAP, ST_WAIT_RES};
    busy_d  = start_d;
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      code_q    <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bt_q      <= 3'b000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      code_q    <= code_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bt_q      <= bt_d;
    end
  end

  assign bus.start   = start_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.timeout = timeout_q;
  assign bus.bt_0    = bt_q[0];
  assign bus.bt_1    = bt_q[1];
  assign bus.bt_2    = bt_q[2];

endmodule

// File: tb/tb_doorlock_code_sender.sv
// Directed bench for doorlock_code_sender: per-session output traces are
// captured cycle by cycle relative to the go edge and compared to hand timing.
module tb_doorlock_code_sender;
  import doorlock_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  doorlock_code_sender_if bus();

  doorlock_code_sender #(
    .LEAD_CYC  (LEAD_CYC_DEF),
    .PRESS_CYC (PRESS_CYC_DEF),
    .GAP_CYC   (GAP_CYC_DEF),
    .WAIT_MAX  (WAIT_MAX_DEF)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int errs   = 0;
  int checks = 0;

  logic [31:0] start_v, busy_v, done_v, bt0_v, bt1_v, bt2_v, multi_v;
  logic        pass_f, tmo_f;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] span(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] bit_at(input int n);
    logic [31:0] m;
    m = '0;
    m[n] = 1'b1;
    return m;
  endfunction

  // {start, busy, done, bt_0, bt_1, bt_2, pass, timeout}
  function automatic logic [31:0] outs();
    return {24'd0, bus.start, bus.busy, bus.done, bus.bt_0, bus.bt_1, bus.bt_2,
            bus.pass, bus.timeout};
  endfunction

  // Bit n of each trace is the output after edge k+n, where k is the go edge.
  // *_at arguments name the edge at which a one-cycle stimulus is sampled.
  task automatic run(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2,
                     input int ok_at, input int fail_at, input int go2_at, input int chg_at);
    @(negedge clk);
    bus.code_0 = c0; bus.code_1 = c1; bus.code_2 = c2;
    bus.go = 1'b1;
    start_v = '0; busy_v = '0; done_v = '0;
    bt0_v = '0; bt1_v = '0; bt2_v = '0; multi_v = '0;
    for (int n = 0; n < 32; n++) begin
      @(posedge clk);
      @(negedge clk);
      start_v[n] = bus.start;
      busy_v[n]  = bus.busy;
      done_v[n]  = bus.done;
      bt0_v[n]   = bus.bt_0;
      bt1_v[n]   = bus.bt_1;
      bt2_v[n]   = bus.bt_2;
      multi_v[n] = (int'(bus.bt_0) + int'(bus.bt_1) + int'(bus.bt_2)) > 1;
      bus.go       = (go2_at == n + 1);
      bus.led_ok   = (ok_at == n + 1);
      bus.led_fail = (fail_at == n + 1);
      if (chg_at == n + 1) begin
        bus.code_0 = c2; bus.code_1 = c0; bus.code_2 = c1;
      end
    end
    pass_f = bus.pass;
    tmo_f  = bus.timeout;
  endtask

  initial begin
    n_rst = 1'b0;
    bus.go = 1'b0; bus.led_ok = 1'b0; bus.led_fail = 1'b0;
    bus.code_0 = 2'd0; bus.code_1 = 2'd0; bus.code_2 = 2'd0;
    #1;
    chk("reset_outs", outs(), 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("idle_outs", outs(), 32'd0);

    // Code 2,0,1 answered by led_ok at k+18.
    run(2'd2, 2'd0, 2'd1, 18, 0, 0, 0);
    chk("ok_start", start_v, span(0, 17));
    chk("ok_busy",  busy_v,  span(0, 17));
    chk("ok_done",  done_v,  bit_at(18));
    chk("ok_bt2",   bt2_v,   bit_at(1));
    chk("ok_bt0",   bt0_v,   bit_at(6));
    chk("ok_bt1",   bt1_v,   bit_at(11));
    chk("ok_multi", multi_v, 32'd0);
    chk("ok_pass",  32'(pass_f), 32'd1);
    chk("ok_tmo",   32'(tmo_f),  32'd0);

    // led_fail at the first WAIT_RES sample.
    run(2'd2, 2'd0, 2'd1, 0, 17, 0, 0);
    chk("fail_start", start_v, span(0, 16));
    chk("fail_done",  done_v,  bit_at(17));
    chk("fail_bt1",   bt1_v,   bit_at(11));
    chk("fail_pass",  32'(pass_f), 32'd0);
    chk("fail_tmo",   32'(tmo_f),  32'd0);

    // No response: the eighth sample at k+24 times out.
    run(2'd2, 2'd0, 2'd1, 0, 0, 0, 0);
    chk("tmo_start", start_v, span(0, 23));
    chk("tmo_busy",  busy_v,  span(0, 23));
    chk("tmo_done",  done_v,  bit_at(24));
    chk("tmo_pass",  32'(pass_f), 32'd0);
    chk("tmo_tmo",   32'(tmo_f),  32'd1);

    // led_ok while idle must not touch the held result.
    @(negedge clk); bus.led_ok = 1'b1;
    @(negedge clk); bus.led_ok = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_led_pass", 32'(bus.pass),    32'd0);
    chk("idle_led_tmo",  32'(bus.timeout), 32'd1);
    chk("idle_led_done", 32'(bus.done),    32'd0);

    // Blank digits: only bt_1 fires, timing unchanged.
    run(2'd3, 2'd1, 2'd3, 18, 0, 0, 0);
    chk("blank_bt0",   bt0_v,   32'd0);
    chk("blank_bt1",   bt1_v,   bit_at(6));
    chk("blank_bt2",   bt2_v,   32'd0);
    chk("blank_start", start_v, span(0, 17));
    chk("blank_done",  done_v,  bit_at(18));
    chk("blank_multi", multi_v, 32'd0);
    chk("blank_pass",  32'(pass_f), 32'd1);

    // Re-pulsed go at k+3 and code change at k+2 are ignored.
    run(2'd2, 2'd0, 2'd1, 18, 0, 3, 2);
    chk("regos_bt2",  bt2_v,  bit_at(1));
    chk("regos_bt0",  bt0_v,  bit_at(6));
    chk("regos_bt1",  bt1_v,  bit_at(11));
    chk("regos_busy", busy_v, span(0, 17));
    chk("regos_done", done_v, bit_at(18));

    // Reset mid-session, right after edge k+7.
    @(negedge clk);
    bus.code_0 = 2'd2; bus.code_1 = 2'd0; bus.code_2 = 2'd1;
    bus.go = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.go = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("rst_pre_busy", 32'(bus.busy), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("rst_abort", outs(), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold", outs(), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_release", outs(), 32'd0);

    run(2'd2, 2'd0, 2'd1, 18, 0, 0, 0);
    chk("post_rst_bt2",  bt2_v,  bit_at(1));
    chk("post_rst_bt0",  bt0_v,  bit_at(6));
    chk("post_rst_bt1",  bt1_v,  bit_at(11));
    chk("post_rst_done", done_v, bit_at(18));
    chk("post_rst_pass", 32'(pass_f), 32'd1);

    // Stale led_fail while idle keeps pass.
    @(negedge clk); bus.led_fail = 1'b1;
    @(negedge clk); bus.led_fail = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_fail_pass", 32'(bus.pass), 32'd1);
    chk("idle_fail_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
